// File: rtl/matrix_spi_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_spi_pkg
// Description : Shared types and defaults for the LED-matrix SPI frame
//               transmitter (state encoding, default frame width).
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_spi_pkg;

    // Transmitter phases: idle, setup before first edge, sck high/low, inter-frame gap
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        GAP   = 3'd4
    } tx_state_t;

    localparam int FRAME_W_DEF = 128;

endpackage
`default_nettype wire

// File: rtl/matrix_spi_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : matrix_spi_tx_if
// Description : Frame handshake and SPI pin bundle for matrix_spi_tx.
//               slave = transmitter side, master = frame source / observer.
//               MATRIX_TX_READBACK_EN adds the sdo/rx_data readback pair.
// Revision    : 1.0 - initial release
// ============================================================================
interface matrix_spi_tx_if #(
    parameter int FRAME_W = matrix_spi_pkg::FRAME_W_DEF
);
    logic [FRAME_W-1:0] frame_data;
    logic               frame_valid;
    logic               frame_ready;
    logic               sck;
    logic               sdi;
    logic               load;
    logic               busy;
    logic               done;
`ifdef MATRIX_TX_READBACK_EN
    logic               sdo;
    logic [FRAME_W-1:0] rx_data;

    modport slave  (input  frame_data, frame_valid, sdo,
                    output frame_ready, sck, sdi, load, busy, done, rx_data);
    modport master (output frame_data, frame_valid, sdo,
                    input  frame_ready, sck, sdi, load, busy, done, rx_data);
`else
    modport slave  (input  frame_data, frame_valid,
                    output frame_ready, sck, sdi, load, busy, done);
    modport master (output frame_data, frame_valid,
                    input  frame_ready, sck, sdi, load, busy, done);
`endif
endinterface
`default_nettype wire

// File: rtl/matrix_spi_tx_half_tick.sv
`default_nettype none
// ============================================================================
// Module      : spi_half_tick
// Description : Half-period counter for the SPI transmitter. Counts DIV
//               cycles per phase, flags the last cycle of a phase and
//               restarts whenever the owning FSM changes state.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_half_tick #(
    parameter int DIV = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic run_i,       // FSM is in a timed sck phase
    input  wire logic restart_i,   // FSM changes state this cycle
    output logic      phase_end_o
);
    localparam int              CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign phase_end_o = run_i && (cnt_q == LAST);

    // Next count: zero outside timed phases, on any state change and at wrap
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!run_i || restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_spi_tx.sv
`default_nettype none
// ============================================================================
// Module      : matrix_spi_tx
// Description : SPI mode-0 frame transmitter for the LED-matrix load link.
//               Accepts one FRAME_W-bit frame on valid/ready and shifts it
//               out MSB first on sck/sdi with load framing the shift window.
//               Optional macro MATRIX_TX_READBACK_EN adds MISO readback
//               (sdo in, rx_data out).
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_spi_tx #(
    parameter int FRAME_W = matrix_spi_pkg::FRAME_W_DEF,
    parameter int DIV     = 4,
    parameter int GAP     = 8
) (
    input  wire logic      clk,
    input  wire logic      reset,
    matrix_spi_tx_if.slave bus
);
    import matrix_spi_pkg::*;

    // The GAP parameter shadows the enum literal of the same name
    localparam tx_state_t        S_GAP    = matrix_spi_pkg::GAP;
    localparam int               BIT_W    = $clog2(FRAME_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
    localparam int               GAP_W    = $clog2(GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    tx_state_t          state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [GAP_W-1:0]   gapcnt_q, gapcnt_d;
    logic               done_q, done_d;

    logic w_shift_win;
    logic w_phase_end;
    logic w_gap_end;

    assign w_shift_win = state_q inside {SETUP, HIGH, LOW};
    assign w_gap_end   = (state_q == S_GAP) && (gapcnt_q == GAP_LAST);

    spi_half_tick #(
        .DIV (DIV)
    ) u_half_tick (
        .clk         (clk),
        .reset       (reset),
        .run_i       (w_shift_win),
        .restart_i   (state_d != state_q),
        .phase_end_o (w_phase_end)
    );

    // Outputs decode registered state only; no input reaches an output
    assign bus.frame_ready = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.sck         = (state_q == HIGH);
    assign bus.load        = w_shift_win;
    assign bus.sdi         = w_shift_win & shreg_q[FRAME_W-1];
    assign bus.done        = done_q;

    // Next-state, shift register, bit and gap counters
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = '0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.frame_valid) begin
                    shreg_d  = bus.frame_data;
                    bitcnt_d = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (w_phase_end) state_d = HIGH;
            end
            HIGH: begin
                // Shifting on the high->low edge keeps sdi changes inside sck low
                if (w_phase_end) begin
                    shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                    state_d = LOW;
                end
            end
            LOW: begin
                if (w_phase_end) begin
                    if (bitcnt_q == LAST_BIT) begin
                        state_d = S_GAP;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                        state_d  = HIGH;
                    end
                end
            end
            S_GAP: begin
                gapcnt_d = gapcnt_q + 1'b1;
                if (w_gap_end) begin
                    gapcnt_d = '0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
            done_q   <= done_d;
        end
    end

`ifdef MATRIX_TX_READBACK_EN
    logic [FRAME_W-1:0] rx_q;

    // Capture MISO on the last cycle of each high phase, MSB first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_q <= '0;
        end else if ((state_q == HIGH) && w_phase_end) begin
            rx_q <= {rx_q[FRAME_W-2:0], bus.sdo};
        end
    end

    assign bus.rx_data = rx_q;
`endif

endmodule
`default_nettype wire
